// File: rtl/issue_pair_split_if.sv
// Fetch-pair / decode-slot bundle for issue_pair_split.
interface issue_pair_split_if #(
  parameter int IWIDTH  = 32,
  parameter int PCWIDTH = 32
);
  logic               ip_i_valid;
  logic [IWIDTH-1:0]  ip_i_instr_1;
  logic [IWIDTH-1:0]  ip_i_instr_2;
  logic [PCWIDTH-1:0] ip_i_pc;
  logic               ip_i_dep;
  logic               ip_i_stall;
  logic               ip_i_flush;
  logic               ip_o_ready;
  logic [IWIDTH-1:0]  ip_o_instr_1;
  logic [IWIDTH-1:0]  ip_o_instr_2;
  logic [PCWIDTH-1:0] ip_o_pc_1;
  logic [PCWIDTH-1:0] ip_o_pc_2;
  logic               ip_o_valid_1;
  logic               ip_o_valid_2;

  modport master (
    output ip_i_valid, ip_i_instr_1, ip_i_instr_2, ip_i_pc, ip_i_dep,
           ip_i_stall, ip_i_flush,
    input  ip_o_ready, ip_o_instr_1, ip_o_instr_2, ip_o_pc_1, ip_o_pc_2,
           ip_o_valid_1, ip_o_valid_2
  );

  modport slave (
    input  ip_i_valid, ip_i_instr_1, ip_i_instr_2, ip_i_pc, ip_i_dep,
           ip_i_stall, ip_i_flush,
    output ip_o_ready, ip_o_instr_1, ip_o_instr_2, ip_o_pc_1, ip_o_pc_2,
           ip_o_valid_1, ip_o_valid_2
  );
endinterface

// File: rtl/issue_pair_split.sv
// Dual-issue split stage: issues a fetch pair together, or over two cycles on intra-pair hazard.
// Optional ISSUE_SPLIT_STATS_EN adds a saturating hazard-pair counter ip_o_split_cnt.
module issue_pair_split #(
  parameter int IWIDTH  = 32,
  parameter int PCWIDTH = 32
) (
  input  logic                ip_i_clk,
  input  logic                ip_i_rst,
  issue_pair_split_if.slave   ip_bus
`ifdef ISSUE_SPLIT_STATS_EN
  ,
  output logic [15:0]         ip_o_split_cnt
`endif
);

  typedef enum logic {S_PAIR, S_SPLIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [IWIDTH-1:0]  r_instr_1, r_instr_2, r_buf_instr;
  logic [PCWIDTH-1:0] r_pc_1, r_pc_2, r_buf_pc;
  logic               r_valid_1, r_valid_2;

  logic [IWIDTH-1:0]  w_instr_1, w_instr_2, w_buf_instr;
  logic [PCWIDTH-1:0] w_pc_1, w_pc_2, w_buf_pc;
  logic               w_valid_1, w_valid_2;
  logic               w_split_accept;
  logic [PCWIDTH-1:0] w_pc_plus4;

  assign w_pc_plus4        = ip_bus.ip_i_pc + PCWIDTH'(4);
  assign ip_bus.ip_o_ready = (r_state == S_PAIR) & ~ip_bus.ip_i_stall & ~ip_bus.ip_i_flush;

  always_ff @(posedge ip_i_clk or posedge ip_i_rst) begin
    if (ip_i_rst) r_state <= S_PAIR;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_1      = r_instr_1;
    w_instr_2      = r_instr_2;
    w_pc_1         = r_pc_1;
    w_pc_2         = r_pc_2;
    w_valid_1      = r_valid_1;
    w_valid_2      = r_valid_2;
    w_buf_instr    = r_buf_instr;
    w_buf_pc       = r_buf_pc;
    w_split_accept = 1'b0;
    if (ip_bus.ip_i_flush) begin
      // Returning to S_PAIR is what discards the buffered instruction.
      w_valid_1   = 1'b0;
      w_valid_2   = 1'b0;
      w_state_nxt = S_PAIR;
    end else if (!ip_bus.ip_i_stall) begin
      unique case (r_state)
        S_PAIR: begin
          if (ip_bus.ip_i_valid) begin
            w_instr_1 = ip_bus.ip_i_instr_1;
            w_pc_1    = ip_bus.ip_i_pc;
            w_valid_1 = 1'b1;
            if (ip_bus.ip_i_dep) begin
              w_valid_2      = 1'b0;
              w_buf_instr    = ip_bus.ip_i_instr_2;
              w_buf_pc       = w_pc_plus4;
              w_split_accept = 1'b1;
              w_state_nxt    = S_SPLIT;
            end else begin
              w_instr_2 = ip_bus.ip_i_instr_2;
              w_pc_2    = w_pc_plus4;
              w_valid_2 = 1'b1;
            end
          end else begin
            w_valid_1 = 1'b0;
            w_valid_2 = 1'b0;
          end
        end
        S_SPLIT: begin
          w_instr_1   = r_buf_instr;
          w_pc_1      = r_buf_pc;
          w_valid_1   = 1'b1;
          w_valid_2   = 1'b0;
          w_state_nxt = S_PAIR;
        end
        default: w_state_nxt = S_PAIR;
      endcase
    end
  end

  always_ff @(posedge ip_i_clk or posedge ip_i_rst) begin
    if (ip_i_rst) begin
      r_instr_1   <= '0;
      r_instr_2   <= '0;
      r_pc_1      <= '0;
      r_pc_2      <= '0;
      r_valid_1   <= 1'b0;
      r_valid_2   <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else begin
      r_instr_1   <= w_instr_1;
      r_instr_2   <= w_instr_2;
      r_pc_1      <= w_pc_1;
      r_pc_2      <= w_pc_2;
      r_valid_1   <= w_valid_1;
      r_valid_2   <= w_valid_2;
      r_buf_instr <= w_buf_instr;
      r_buf_pc    <= w_buf_pc;
    end
  end

  assign ip_bus.ip_o_instr_1 = r_instr_1;
  assign ip_bus.ip_o_instr_2 = r_instr_2;
  assign ip_bus.ip_o_pc_1    = r_pc_1;
  assign ip_bus.ip_o_pc_2    = r_pc_2;
  assign ip_bus.ip_o_valid_1 = r_valid_1;
  assign ip_bus.ip_o_valid_2 = r_valid_2;

`ifdef ISSUE_SPLIT_STATS_EN
  logic [15:0] r_split_cnt;

  // Flush does not clear this: a hazard pair that was accepted still counts.
  always_ff @(posedge ip_i_clk or posedge ip_i_rst) begin
    if (ip_i_rst)
      r_split_cnt <= '0;
    else if (w_split_accept && (r_split_cnt != 16'hFFFF))
      r_split_cnt <= r_split_cnt + 16'd1;
  end

  assign ip_o_split_cnt = r_split_cnt;
`else
  logic w_unused;
  assign w_unused = w_split_accept;
`endif

endmodule

// File: tb/tb_issue_pair_split.sv
// Directed scoreboard bench for issue_pair_split; define ISSUE_SPLIT_STATS_EN to cover the counter.
module tb_issue_pair_split;

  typedef struct {
    logic        v1;
    logic        v2;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] pc1;
    logic [31:0] pc2;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;
  exp_t sb[$];

  issue_pair_split_if #(.IWIDTH(32), .PCWIDTH(32)) bus ();
`ifdef ISSUE_SPLIT_STATS_EN
  logic [15:0] split_cnt;
`endif

  issue_pair_split #(.IWIDTH(32), .PCWIDTH(32)) dut (
    .ip_i_clk (clk),
    .ip_i_rst (rst),
    .ip_bus   (bus.slave)
`ifdef ISSUE_SPLIT_STATS_EN
    ,
    .ip_o_split_cnt (split_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic [31:0] i1,
                       input logic [31:0] i2, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.ip_i_valid   = v;
    bus.ip_i_dep     = d;
    bus.ip_i_instr_1 = i1;
    bus.ip_i_instr_2 = i2;
    bus.ip_i_pc      = pc;
    bus.ip_i_stall   = st;
    bus.ip_i_flush   = fl;
    #1;
  endtask

  task automatic push(input logic v1, input logic v2, input logic [31:0] i1,
                      input logic [31:0] i2, input logic [31:0] pc1, input logic [31:0] pc2);
    exp_t e;
    e.v1 = v1; e.v2 = v2; e.i1 = i1; e.i2 = i2; e.pc1 = pc1; e.pc2 = pc2;
    sb.push_back(e);
  endtask

  // Advance one clock and compare outputs against the oldest expected entry.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_v1"}, {31'd0, bus.ip_o_valid_1}, {31'd0, e.v1});
      chk({tag, "_v2"}, {31'd0, bus.ip_o_valid_2}, {31'd0, e.v2});
      if (e.v1) begin
        chk({tag, "_i1"}, bus.ip_o_instr_1, e.i1);
        chk({tag, "_pc1"}, bus.ip_o_pc_1, e.pc1);
      end
      if (e.v2) begin
        chk({tag, "_i2"}, bus.ip_o_instr_2, e.i2);
        chk({tag, "_pc2"}, bus.ip_o_pc_2, e.pc2);
      end
    end
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, "_ready"}, {31'd0, bus.ip_o_ready}, {31'd0, exp});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v1", {31'd0, bus.ip_o_valid_1}, 32'd0);
    chk("rst_v2", {31'd0, bus.ip_o_valid_2}, 32'd0);
    chk("rst_i1", bus.ip_o_instr_1, 32'd0);
    chk("rst_pc2", bus.ip_o_pc_2, 32'd0);
    chk_rdy("rst", 1'b1);
`ifdef ISSUE_SPLIT_STATS_EN
    chk("rst_cnt", {16'd0, split_cnt}, 32'd0);
`endif
    rst = 1'b0;

    // No hazard
    drive(1'b1, 1'b0, 32'hA000_0001, 32'hA000_0002, 32'h100, 1'b0, 1'b0);
    chk_rdy("nohz", 1'b1);
    push(1'b1, 1'b1, 32'hA000_0001, 32'hA000_0002, 32'h100, 32'h104);
    tick("nohz");

    // Hazard: split over two cycles, next pair blocked while splitting
    drive(1'b1, 1'b1, 32'hB000_0001, 32'hB000_0002, 32'h200, 1'b0, 1'b0);
    chk_rdy("hz_acc", 1'b1);
    push(1'b1, 1'b0, 32'hB000_0001, 32'h0, 32'h200, 32'h0);
    tick("hz_c1");
    drive(1'b1, 1'b0, 32'hC000_0001, 32'hC000_0002, 32'h300, 1'b0, 1'b0);
    chk_rdy("hz_split", 1'b0);
    push(1'b1, 1'b0, 32'hB000_0002, 32'h0, 32'h204, 32'h0);
    tick("hz_c2");
    chk_rdy("hz_back", 1'b1);
    push(1'b1, 1'b1, 32'hC000_0001, 32'hC000_0002, 32'h300, 32'h304);
    tick("after_hz");

    // Stall three cycles in S_SPLIT
    drive(1'b1, 1'b1, 32'hD000_0001, 32'hD000_0002, 32'h400, 1'b0, 1'b0);
    push(1'b1, 1'b0, 32'hD000_0001, 32'h0, 32'h400, 32'h0);
    tick("st_acc");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'hEEEE_0000, 32'hEEEE_1111, 32'h900, 1'b1, 1'b0);
      chk_rdy("st_hold", 1'b0);
      push(1'b1, 1'b0, 32'hD000_0001, 32'h0, 32'h400, 32'h0);
      tick("st_hold");
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk_rdy("st_rel", 1'b0);
    push(1'b1, 1'b0, 32'hD000_0002, 32'h0, 32'h404, 32'h0);
    tick("st_rel");

    // Flush in S_SPLIT with valid input
    drive(1'b1, 1'b1, 32'hE000_0001, 32'hE000_0002, 32'h500, 1'b0, 1'b0);
    push(1'b1, 1'b0, 32'hE000_0001, 32'h0, 32'h500, 32'h0);
    tick("fl_acc");
    drive(1'b1, 1'b0, 32'hF000_0001, 32'hF000_0002, 32'h600, 1'b0, 1'b1);
    chk_rdy("fl", 1'b0);
    push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("fl");
    drive(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0);
    chk_rdy("fl_after", 1'b1);
    push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("fl_after");

    // PC wrap; dep ignored when not valid was covered just above
    drive(1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk_rdy("wrap", 1'b1);
    push(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFC, 32'h0000_0000);
    tick("wrap");

`ifdef ISSUE_SPLIT_STATS_EN
    chk("cnt3", {16'd0, split_cnt}, 32'd3);
`endif
    // Reset mid-split
    drive(1'b1, 1'b1, 32'h7000_0001, 32'h7000_0002, 32'h700, 1'b0, 1'b0);
    push(1'b1, 1'b0, 32'h7000_0001, 32'h0, 32'h700, 32'h0);
    tick("mr_acc");
`ifdef ISSUE_SPLIT_STATS_EN
    chk("cnt4", {16'd0, split_cnt}, 32'd4);
`endif
    chk_rdy("mr_split", 1'b0);
    rst = 1'b1;
    #1;
    chk("mr_v1", {31'd0, bus.ip_o_valid_1}, 32'd0);
    chk("mr_v2", {31'd0, bus.ip_o_valid_2}, 32'd0);
    chk("mr_i1", bus.ip_o_instr_1, 32'd0);
    chk("mr_pc1", bus.ip_o_pc_1, 32'd0);
    chk_rdy("mr", 1'b1);
`ifdef ISSUE_SPLIT_STATS_EN
    chk("mr_cnt", {16'd0, split_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("mr_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
